// File: rtl/password_checker.sv
// rtl/password_checker.sv - keypad password entry, ROM scan compare, grant/deny and lockout
module password_checker #(
    parameter int NUM_DIGITS  = 5,
    parameter int NUM_ENTRIES = 8,
    parameter int ROM_LATENCY = 2,
    parameter int MAX_TRIES   = 3,
    parameter logic [4*NUM_DIGITS-1:0] EMPTY_WORD = 20'hFFFFF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     digit_in,
    input  logic                           digit_valid,
    input  logic                           clear,
    input  logic [4*NUM_DIGITS-1:0]        rom_q,
    output logic [$clog2(NUM_ENTRIES)-1:0] rom_addr,
    output logic                           busy,
    output logic                           access_granted,
    output logic                           access_denied,
    output logic [$clog2(NUM_ENTRIES)-1:0] user_id,
    output logic                           locked
);

    localparam int WORD_W = 4 * NUM_DIGITS;
    localparam int AW     = $clog2(NUM_ENTRIES);
    localparam int CW     = $clog2(NUM_DIGITS + 1);
    localparam int WW     = $clog2(ROM_LATENCY + 1);
    localparam int FW     = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_SEARCH,
        ST_GRANT,
        ST_DENY,
        ST_LOCK
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pass_q, pass_d;
    logic [CW-1:0]     digit_cnt_q, digit_cnt_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [FW-1:0]     fail_cnt_q, fail_cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     uid_q, uid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTRY;
            pass_q      <= '0;
            digit_cnt_q <= '0;
            wait_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            addr_q      <= '0;
            uid_q       <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            digit_cnt_q <= digit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            addr_q      <= addr_d;
            uid_q       <= uid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        digit_cnt_d = digit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        addr_d      = addr_q;
        uid_d       = uid_q;
        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    pass_d      = '0;
                    digit_cnt_d = '0;
                end else if (digit_valid && (digit_in <= 4'd9)) begin
                    pass_d = {pass_q[WORD_W-5:0], digit_in};
                    if (digit_cnt_q == CW'(NUM_DIGITS - 1)) begin
                        state_d     = ST_SEARCH;
                        digit_cnt_d = '0;
                        addr_d      = '0;
                        wait_cnt_d  = '0;
                    end else begin
                        digit_cnt_d = digit_cnt_q + 1'b1;
                    end
                end
            end
            ST_SEARCH: begin
                // rom_q reflects addr_q only once ROM_LATENCY clocks have elapsed
                if (wait_cnt_q == WW'(ROM_LATENCY)) begin
                    if ((rom_q == pass_q) && (rom_q != EMPTY_WORD)) begin
                        state_d = ST_GRANT;
                        uid_d   = addr_q;
                    end else if (addr_q == AW'(NUM_ENTRIES - 1)) begin
                        state_d = ST_DENY;
                    end else begin
                        addr_d     = addr_q + 1'b1;
                        wait_cnt_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_GRANT: begin
                fail_cnt_d = '0;
                pass_d     = '0;
                state_d    = ST_ENTRY;
            end
            ST_DENY: begin
                pass_d     = '0;
                fail_cnt_d = fail_cnt_q + 1'b1;
                state_d    = (fail_cnt_q + 1'b1 >= FW'(MAX_TRIES)) ? ST_LOCK : ST_ENTRY;
            end
            ST_LOCK: begin
                state_d = ST_LOCK;
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    always_comb begin
        busy           = (state_q == ST_SEARCH);
        access_granted = (state_q == ST_GRANT);
        access_denied  = (state_q == ST_DENY);
        locked         = (state_q == ST_LOCK);
        rom_addr       = addr_q;
        user_id        = uid_q;
    end

endmodule

// File: tb/tb_password_checker.sv
// tb/tb_password_checker.sv - randomized self-checking bench for password_checker
module tb_password_checker;

    localparam int ND = 5;
    localparam int NE = 8;
    localparam logic [19:0] EMPTY = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        clear;
    logic [19:0] rom_q;
    logic [2:0]  rom_addr;
    logic        busy;
    logic        access_granted;
    logic        access_denied;
    logic [2:0]  user_id;
    logic        locked;

    password_checker dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
        .clear(clear), .rom_q(rom_q), .rom_addr(rom_addr), .busy(busy),
        .access_granted(access_granted), .access_denied(access_denied),
        .user_id(user_id), .locked(locked)
    );

    always #5 clk = ~clk;

    // two-clock ROM
    logic [19:0] rom [NE];
    logic [19:0] rom_p1;
    always @(posedge clk) begin
        rom_p1 <= rom[rom_addr];
        rom_q  <= rom_p1;
    end

    int errors = 0;
    int checks = 0;

    // reference model state
    int       keyq[$];
    int       m_fails;
    bit       m_locked;
    int       m_uid;
    bit       strobe_busy;

    task automatic apply_reset();
        rst = 1'b1; digit_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        keyq.delete(); m_fails = 0; m_locked = 1'b0; m_uid = 0;
    endtask

    task automatic check_search(input logic [19:0] code, input string name);
        bit exp_grant;
        int idx, exp_lat, n, busy_cnt;
        bit got;
        exp_grant = 1'b0; idx = 0;
        for (int i = NE - 1; i >= 0; i--)
            if (rom[i] == code && code != EMPTY) begin exp_grant = 1'b1; idx = i; end
        exp_lat  = exp_grant ? 3 * (idx + 1) : 3 * NE;
        n = 0; busy_cnt = 0; got = 1'b0;
        while (n < 80 && !got) begin
            if (access_granted || access_denied) got = 1'b1;
            else begin
                if (busy) begin
                    busy_cnt++;
                    if (strobe_busy) begin
                        digit_valid = 1'b1;
                        digit_in    = 4'($urandom_range(0, 15));
                        clear       = 1'($urandom_range(0, 1));
                    end
                end
                @(negedge clk);
                digit_valid = 1'b0; clear = 1'b0;
                n++;
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s timeout: no pulse after %0d cycles, required one", name, n); end
        checks++;
        if (n !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d required %0d", name, n, exp_lat); end
        checks++;
        if (busy_cnt !== exp_lat) begin errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_lat); end
        checks++;
        if (access_granted !== exp_grant || access_denied !== !exp_grant) begin
            errors++;
            $display("FAIL %s pulse: granted=%b denied=%b required granted=%b", name, access_granted, access_denied, exp_grant);
        end
        if (exp_grant) begin m_uid = idx; m_fails = 0; end
        else begin m_fails++; if (m_fails >= 3) m_locked = 1'b1; end
        checks++;
        if (user_id !== 3'(m_uid)) begin errors++; $display("FAIL %s user_id: got %0d required %0d", name, user_id, m_uid); end
        @(negedge clk);
        checks++;
        if (access_granted !== 1'b0 || access_denied !== 1'b0 || busy !== 1'b0 || locked !== m_locked) begin
            errors++;
            $display("FAIL %s after_pulse: granted=%b denied=%b busy=%b locked=%b required 0 0 0 %b",
                     name, access_granted, access_denied, busy, locked, m_locked);
        end
    endtask

    // k: 0..15 digit nibble, 16 clear, 17 clear together with a valid digit
    task automatic key(input int k, input string name);
        logic [19:0] code;
        if (k >= 16) begin
            clear = 1'b1;
            if (k == 17) begin digit_valid = 1'b1; digit_in = 4'($urandom_range(0, 9)); end
            @(negedge clk);
            clear = 1'b0; digit_valid = 1'b0;
            if (!m_locked) keyq.delete();
        end else begin
            digit_in = 4'(k); digit_valid = 1'b1;
            @(negedge clk);
            digit_valid = 1'b0;
            if (!m_locked && k <= 9) begin
                keyq.push_back(k);
                if (keyq.size() == ND) begin
                    code = '0;
                    foreach (keyq[i]) code = {code[15:0], 4'(keyq[i])};
                    keyq.delete();
                    check_search(code, name);
                end
            end
        end
    endtask

    task automatic enter_code(input logic [19:0] code, input string name);
        for (int i = ND - 1; i >= 0; i--) key(int'((code >> (4 * i)) & 20'hF), name);
    endtask

    task automatic test_reset();
        checks++;
        if ({rom_addr, busy, access_granted, access_denied, user_id, locked} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d busy=%b g=%b d=%b uid=%0d lk=%b required all 0",
                     rom_addr, busy, access_granted, access_denied, user_id, locked);
        end
        rst = 1'b0;
    endtask

    task automatic test_grant();
        enter_code(20'h12345, "grant_lowest");
    endtask

    task automatic test_deny();
        enter_code(20'h99999, "deny_absent");
    endtask

    task automatic test_invalid_digits();
        for (int i = 0; i < 5; i++) key(15, "invalid_f");
        for (int i = 10; i < 15; i++) key(i, "invalid_hex");
        enter_code(20'h12345, "invalid_then_grant");
    endtask

    task automatic test_clear();
        key(1, "clear"); key(2, "clear"); key(16, "clear");
        enter_code(20'h12345, "clear_then_grant");
        key(9, "clear_wins"); key(17, "clear_wins");
        strobe_busy = 1'b1;
        enter_code(20'h54321, "busy_strobes");
        enter_code(20'h24680, "busy_strobes2");
        strobe_busy = 1'b0;
    endtask

    task automatic test_lockout();
        int bad;
        for (int t = 0; t < 3; t++) enter_code(20'h99999, "lockout_deny");
        bad = 0;
        for (int i = 0; i < 5; i++) key(1 + i, "locked_keys");
        for (int i = 0; i < 20; i++) begin
            if (busy || access_granted || access_denied || !locked) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL locked_hold: %0d bad cycles, required 0", bad); end
        apply_reset();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL unlock_by_rst: locked=%b required 0", locked); end
    endtask

    task automatic test_reset_mid_search();
        int bad;
        enter_code(20'h99999, "pre_abort_deny");
        for (int i = 4; i >= 1; i--) key(5 - i, "abort");
        digit_in = 4'd5; digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (rom_addr !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_setup: addr=%0d busy=%b required 2 1", rom_addr, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rom_addr, busy, access_granted, access_denied, user_id, locked} !== 10'd0) begin
            errors++;
            $display("FAIL abort_outputs: addr=%0d busy=%b g=%b d=%b uid=%0d lk=%b required all 0",
                     rom_addr, busy, access_granted, access_denied, user_id, locked);
        end
        rst = 1'b0;
        keyq.delete(); m_fails = 0; m_locked = 1'b0; m_uid = 0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy || access_granted || access_denied) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_no_pulse: %0d bad cycles, required 0", bad); end
        enter_code(20'h99999, "post_abort_deny1");
        enter_code(20'h99999, "post_abort_deny2");
    endtask

    task automatic test_random();
        logic [19:0] code;
        int r;
        for (int it = 0; it < 40; it++) begin
            strobe_busy = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 5) begin
                code = rom[$urandom_range(0, NE - 1)];
                if (code == EMPTY) code = rom[3];
            end else begin
                code = '0;
                for (int i = 0; i < ND; i++) code = {code[15:0], 4'($urandom_range(0, 9))};
            end
            for (int i = ND - 1; i >= 0; i--) begin
                if ($urandom_range(0, 9) == 0) key($urandom_range(10, 15), "rand_inval");
                if ($urandom_range(0, 19) == 0) key($urandom_range(16, 17), "rand_clear");
                key(int'((code >> (4 * i)) & 20'hF), "random");
            end
            if (m_locked) apply_reset();
        end
        strobe_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; digit_valid = 1'b0; clear = 1'b0; digit_in = 4'd0;
        strobe_busy = 1'b0;
        keyq.delete(); m_fails = 0; m_locked = 1'b0; m_uid = 0;
        rom[0] = 20'h54321; rom[1] = 20'h11111; rom[2] = 20'h98765; rom[3] = 20'h12345;
        rom[4] = 20'h13579; rom[5] = EMPTY;     rom[6] = 20'h12345; rom[7] = 20'h24680;
        repeat (3) @(negedge clk);
        test_reset();
        test_grant();
        test_deny();
        test_invalid_digits();
        test_clear();
        test_lockout();
        test_reset_mid_search();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
